// File: rtl/stack_unit.sv
// Operand stack with stack pointer for the single-cycle stack CPU.
// Optional over/underflow guarding is enabled by defining STACK_GUARD_EN.
module stack_unit #(
   parameter int REG_BITS = 32,
   parameter int ADDR_W   = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                commit,
   input  logic [1:0]          stack_update_mode,
   input  logic [1:0]          stack_write_src,
   input  logic [REG_BITS-1:0] alu_result,
   input  logic [REG_BITS-1:0] dmem_rdata,
   input  logic [REG_BITS-1:0] pc_temp,
   output logic [REG_BITS-1:0] tos,
   output logic [REG_BITS-1:0] nos,
   output logic [ADDR_W:0]     sp,
   output logic                empty,
   output logic                full,
   output logic                stack_err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int SP_W  = ADDR_W + 1;

   logic [SP_W-1:0]     sp_q, sp_d, sp_next;
   logic [REG_BITS-1:0] mem_q [DEPTH];
   logic [REG_BITS-1:0] mem_d [DEPTH];
   logic                err_q, err_d;
   logic [REG_BITS-1:0] wr_data;
   logic [ADDR_W-1:0]   wr_idx, tos_idx, nos_idx;
   logic                guard_fault;

   always_comb begin
      sp_next = sp_q;
      unique case (stack_update_mode)
         2'b00: sp_next = sp_q;
         2'b01: sp_next = sp_q + SP_W'(1);
         2'b10: sp_next = sp_q - SP_W'(2);
         2'b11: sp_next = sp_q - SP_W'(1);
      endcase
   end

   always_comb begin
      wr_data = '0;
      unique case (stack_write_src)
         2'b00: wr_data = '0;
         2'b01: wr_data = alu_result;
         2'b10: wr_data = dmem_rdata;
         2'b11: wr_data = pc_temp;
      endcase
   end

   // Indices use the low ADDR_W bits, so pointer arithmetic wraps modulo DEPTH.
   assign wr_idx  = ADDR_W'(sp_next - SP_W'(1));
   assign tos_idx = ADDR_W'(sp_q - SP_W'(1));
   assign nos_idx = ADDR_W'(sp_q - SP_W'(2));

`ifdef STACK_GUARD_EN
   always_comb begin
      guard_fault = 1'b0;
      unique case (stack_update_mode)
         2'b00: guard_fault = (stack_write_src != 2'b00) && (sp_q == '0);
         2'b01: guard_fault = (sp_q == SP_W'(DEPTH));
         2'b10: guard_fault = (sp_q < SP_W'(2));
         2'b11: guard_fault = (stack_write_src != 2'b00) ? (sp_q < SP_W'(2))
                                                         : (sp_q == '0);
      endcase
   end
`else
   assign guard_fault = 1'b0;
`endif

   always_comb begin
      sp_d  = sp_q;
      err_d = err_q;
      mem_d = mem_q;
      if (commit) begin
         if (guard_fault) begin
            err_d = 1'b1;
         end else begin
            sp_d = sp_next;
            if (stack_write_src != 2'b00) begin
               mem_d[wr_idx] = wr_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp_q  <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         sp_q  <= sp_d;
         err_q <= err_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign sp        = sp_q;
   assign empty     = (sp_q == '0);
   assign full      = (sp_q == SP_W'(DEPTH));
   assign tos       = (sp_q == '0) ? '0 : mem_q[tos_idx];
   assign nos       = (sp_q < SP_W'(2)) ? '0 : mem_q[nos_idx];
   assign stack_err = err_q;

endmodule

// File: tb/tb_stack_unit.sv
// Randomized and directed self-checking bench for stack_unit, compared against
// an array-based reference model of the stack; honours STACK_GUARD_EN.
module tb_stack_unit;

   logic        clk;
   logic        reset_n;
   logic        commit;
   logic [1:0]  stack_update_mode;
   logic [1:0]  stack_write_src;
   logic [31:0] alu_result;
   logic [31:0] dmem_rdata;
   logic [31:0] pc_temp;
   logic [31:0] tos;
   logic [31:0] nos;
   logic [4:0]  sp;
   logic        empty;
   logic        full;
   logic        stack_err;

   int testCount = 0;
   int failCount = 0;

   int          modelSp;
   logic [31:0] modelMem [16];
   logic        modelErr;

   stack_unit #(.REG_BITS(32), .ADDR_W(4)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .commit(commit),
      .stack_update_mode(stack_update_mode),
      .stack_write_src(stack_write_src),
      .alu_result(alu_result),
      .dmem_rdata(dmem_rdata),
      .pc_temp(pc_temp),
      .tos(tos),
      .nos(nos),
      .sp(sp),
      .empty(empty),
      .full(full),
      .stack_err(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic void modelReset();
      modelSp  = 0;
      modelErr = 1'b0;
      for (int i = 0; i < 16; i++) modelMem[i] = 32'h0;
   endfunction

   // Stack semantics: a count of entries, where entry k lives at (k-1) mod 16.
   function automatic void modelCommit(input int mode, input int src,
                                       input logic [31:0] a, input logic [31:0] d,
                                       input logic [31:0] p);
      int delta;
      int newSp;
      logic [31:0] value;
      delta = (mode == 1) ? 1 : (mode == 2) ? -2 : (mode == 3) ? -1 : 0;
`ifdef STACK_GUARD_EN
      if ((mode == 1 && modelSp == 16) || (mode == 2 && modelSp < 2) ||
          (mode == 3 && modelSp < 1) || (mode == 3 && src != 0 && modelSp < 2) ||
          (mode == 0 && src != 0 && modelSp == 0)) begin
         modelErr = 1'b1;
         return;
      end
`endif
      newSp = (modelSp + delta + 32) % 32;
      value = (src == 1) ? a : (src == 2) ? d : p;
      if (src != 0) modelMem[(newSp + 31) % 16] = value;
      modelSp = newSp;
   endfunction

   task automatic checkAll(input string tag);
      logic [31:0] expTos;
      logic [31:0] expNos;
      expTos = (modelSp == 0) ? 32'h0 : modelMem[(modelSp + 15) % 16];
      expNos = (modelSp < 2) ? 32'h0 : modelMem[(modelSp + 14) % 16];
      checkOutput({tag, "_sp"}, {27'h0, sp}, 32'(modelSp));
      checkOutput({tag, "_tos"}, tos, expTos);
      checkOutput({tag, "_nos"}, nos, expNos);
      checkOutput({tag, "_empty"}, {31'h0, empty}, {31'h0, modelSp == 0});
      checkOutput({tag, "_full"}, {31'h0, full}, {31'h0, modelSp == 16});
      checkOutput({tag, "_err"}, {31'h0, stack_err}, {31'h0, modelErr});
   endtask

   task automatic applyStimulus(input string tag, input logic c, input logic [1:0] m,
                                input logic [1:0] s, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] p);
      @(negedge clk);
      commit            = c;
      stack_update_mode = m;
      stack_write_src   = s;
      alu_result        = a;
      dmem_rdata        = d;
      pc_temp           = p;
      @(posedge clk);
      if (c) modelCommit(int'(m), int'(s), a, d, p);
      #1;
      checkAll(tag);
   endtask

   // Reset is asserted away from any edge with a push pending, and checked at once.
   task automatic doReset(input string tag);
      @(negedge clk);
      commit            = 1'b1;
      stack_update_mode = 2'b01;
      stack_write_src   = 2'b01;
      alu_result        = 32'hDEAD_BEEF;
      #2;
      reset_n = 1'b0;
      modelReset();
      #1;
      checkAll(tag);
      @(negedge clk);
      commit  = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      applyStimulus(tag, 1'b1, 2'b01, 2'b01, v, 32'h0, 32'h0);
   endtask

   initial begin
      reset_n           = 1'b0;
      commit            = 1'b0;
      stack_update_mode = 2'b00;
      stack_write_src   = 2'b00;
      alu_result        = 32'h0;
      dmem_rdata        = 32'h0;
      pc_temp           = 32'h0;
      modelReset();
      #12;
      checkAll("init");
      @(negedge clk);
      reset_n = 1'b1;

      push("t2a", 32'd5);
      push("t2b", 32'd7);
      checkOutput("t2_tos", tos, 32'd7);
      checkOutput("t2_nos", nos, 32'd5);
      applyStimulus("t2c", 1'b1, 2'b11, 2'b01, 32'd12, 32'h0, 32'h0);
      checkOutput("t2_binop_tos", tos, 32'd12);
      checkOutput("t2_binop_sp", {27'h0, sp}, 32'd1);

      doReset("t1");

      push("t3a", 32'h40);
      applyStimulus("t3b", 1'b1, 2'b00, 2'b10, 32'h0, 32'h99, 32'h0);
      checkOutput("t3_load_tos", tos, 32'h99);
      applyStimulus("t3c", 1'b1, 2'b01, 2'b11, 32'h0, 32'h0, 32'h21);
      checkOutput("t3_pushpc_tos", tos, 32'h21);
      applyStimulus("t3d", 1'b1, 2'b11, 2'b00, 32'h0, 32'h0, 32'h0);
      checkOutput("t3_pop_tos", tos, 32'h99);

      doReset("t4rst");
      for (int i = 0; i < 16; i++) push("t4fill", 32'h100 + 32'(i));
      checkOutput("t4_full", {31'h0, full}, 32'd1);
      push("t4over", 32'hABC);
`ifdef STACK_GUARD_EN
      checkOutput("t4_over_sp", {27'h0, sp}, 32'd16);
      checkOutput("t4_over_err", {31'h0, stack_err}, 32'd1);
      checkOutput("t4_over_tos", tos, 32'h10F);
`else
      checkOutput("t4_wrap_sp", {27'h0, sp}, 32'd17);
      checkOutput("t4_wrap_tos", tos, 32'hABC);
      checkOutput("t4_wrap_err", {31'h0, stack_err}, 32'd0);
`endif

      doReset("t5rst");
      push("t5a", 32'h55);
      applyStimulus("t5b", 1'b1, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0);
      push("t5c", 32'h66);
      push("t5d", 32'h77);
`ifdef STACK_GUARD_EN
      checkOutput("t5_err_sticky", {31'h0, stack_err}, 32'd1);
      checkOutput("t5_sp", {27'h0, sp}, 32'd3);
`endif

      for (int i = 0; i < 3; i++)
         applyStimulus("t6", 1'b0, 2'b01, 2'b01, 32'h1234 + 32'(i), 32'h0, 32'h0);

      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 149) doReset("rnd_rst");
         applyStimulus("rnd", ($urandom_range(0, 9) != 0),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       $urandom, $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
